// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: bubble encoding, BTB counter states, BTB entry layout.
package fetch_stage_pkg;

   localparam int unsigned BTB_WAYS   = 4;
   localparam int unsigned BTB_AW_MAX = 64;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

   typedef enum logic [1:0] {
      CNT_SNT = 2'd0,
      CNT_WNT = 2'd1,
      CNT_WT  = 2'd2,
      CNT_ST  = 2'd3
   } ctr_e;

   // Tag and target are stored at maximum width; narrower configurations zero-extend.
   typedef struct packed {
      logic                  valid;
      logic [BTB_AW_MAX-1:0] tag;
      logic [BTB_AW_MAX-1:0] target;
      ctr_e                  ctr;
   } btb_entry_t;

   function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
      ctr_e n;
      n = c;
      if (taken) begin
         if (c != CNT_ST) n = ctr_e'(c + 2'd1);
      end else begin
         if (c != CNT_SNT) n = ctr_e'(c - 2'd1);
      end
      return n;
   endfunction

endpackage

// File: rtl/fetch_stage_btb.sv
// 4-way set-associative branch target buffer with 2-bit counters and per-set round-robin replacement.
module fetch_stage_btb
   import fetch_stage_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned BTB_SETS   = 16
) (
   input  logic                  i_clk,
   input  logic                  i_arst,
   input  logic [ADDR_WIDTH-1:0] i_pc,
   output logic                  o_taken,
   output logic [ADDR_WIDTH-1:0] o_target,
   output logic [1:0]            o_way,
   input  logic                  i_upd,
   input  logic [ADDR_WIDTH-1:0] i_upd_pc,
   input  logic [ADDR_WIDTH-1:0] i_upd_target,
   input  logic [1:0]            i_upd_way,
   input  logic                  i_upd_taken
);

   localparam int unsigned IDX_W = $clog2(BTB_SETS);
   localparam int unsigned TAG_W = ADDR_WIDTH - 2 - IDX_W;

   btb_entry_t r_mem [BTB_SETS][BTB_WAYS];
   logic [1:0] r_rr  [BTB_SETS];

   logic [IDX_W-1:0]      w_idx;
   logic [IDX_W-1:0]      w_uidx;
   logic [BTB_AW_MAX-1:0] w_tag;
   logic [BTB_AW_MAX-1:0] w_utag;
   logic                  w_uhit;
   logic                  w_unused_bits;

   assign w_idx         = i_pc[2 +: IDX_W];
   assign w_uidx        = i_upd_pc[2 +: IDX_W];
   assign w_tag         = BTB_AW_MAX'(i_pc[ADDR_WIDTH-1 -: TAG_W]);
   assign w_utag        = BTB_AW_MAX'(i_upd_pc[ADDR_WIDTH-1 -: TAG_W]);
   assign w_unused_bits = ^{i_pc[1:0], i_upd_pc[1:0]};

   always_comb begin
      o_taken  = 1'b0;
      o_target = '0;
      o_way    = r_rr[w_idx];
      for (int unsigned w = 0; w < BTB_WAYS; w++) begin
         if (r_mem[w_idx][w].valid && (r_mem[w_idx][w].tag == w_tag)) begin
            o_taken  = r_mem[w_idx][w].ctr[1];
            o_target = r_mem[w_idx][w].target[ADDR_WIDTH-1:0];
            o_way    = 2'(w);
         end
      end
   end

   assign w_uhit = r_mem[w_uidx][i_upd_way].valid && (r_mem[w_uidx][i_upd_way].tag == w_utag);

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         for (int unsigned s = 0; s < BTB_SETS; s++) begin
            r_rr[s] <= '0;
            for (int unsigned w = 0; w < BTB_WAYS; w++) begin
               r_mem[s][w] <= '0;
            end
         end
      end else if (i_upd) begin
         if (w_uhit) begin
            r_mem[w_uidx][i_upd_way].ctr <= ctr_next(r_mem[w_uidx][i_upd_way].ctr, i_upd_taken);
            if (i_upd_taken) r_mem[w_uidx][i_upd_way].target <= BTB_AW_MAX'(i_upd_target);
         end else begin
            r_mem[w_uidx][i_upd_way] <= '{valid:  1'b1,
                                          tag:    w_utag,
                                          target: BTB_AW_MAX'(i_upd_target),
                                          ctr:    (i_upd_taken ? CNT_WT : CNT_WNT)};
            r_rr[w_uidx] <= r_rr[w_uidx] + 2'd1;
         end
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// RV64 instruction fetch stage: PC, next-PC selection and fetch/decode register.
// Define BTB_EN to enable branch target buffer prediction; otherwise always predicts not-taken.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH  = 64,
   parameter int unsigned           INSTR_WIDTH = 32,
   parameter int unsigned           BTB_SETS    = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                   i_clk,
   input  logic                   i_arst,
   input  logic [INSTR_WIDTH-1:0] i_instr,
   input  logic                   i_instr_valid,
   input  logic                   i_stall_fetch,
   input  logic                   i_flush_dec,
   input  logic                   i_branch_mispred,
   input  logic [ADDR_WIDTH-1:0]  i_pc_new,
   input  logic                   i_btb_update,
   input  logic [ADDR_WIDTH-1:0]  i_pc_exec,
   input  logic [ADDR_WIDTH-1:0]  i_pc_target_exec,
   input  logic [1:0]             i_btb_way_exec,
   input  logic                   i_branch_taken_exec,
   output logic [ADDR_WIDTH-1:0]  o_imem_addr,
   output logic [INSTR_WIDTH-1:0] o_instruction,
   output logic [ADDR_WIDTH-1:0]  o_pc,
   output logic [ADDR_WIDTH-1:0]  o_pc_plus4,
   output logic [ADDR_WIDTH-1:0]  o_pc_target_pred,
   output logic [1:0]             o_btb_way,
   output logic                   o_branch_pred_taken
);

   logic [ADDR_WIDTH-1:0]  r_pc;
   logic [INSTR_WIDTH-1:0] r_instr;
   logic [ADDR_WIDTH-1:0]  r_fd_pc;
   logic [ADDR_WIDTH-1:0]  r_fd_pc_plus4;
   logic [ADDR_WIDTH-1:0]  r_fd_target;
   logic [1:0]             r_fd_way;
   logic                   r_fd_taken;

   logic [ADDR_WIDTH-1:0]  w_pc_plus4;
   logic                   w_pred_taken;
   logic [ADDR_WIDTH-1:0]  w_pred_target;
   logic [1:0]             w_pred_way;

   assign w_pc_plus4 = r_pc + ADDR_WIDTH'(4);

`ifdef BTB_EN
   fetch_stage_btb #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .BTB_SETS   (BTB_SETS)
   ) u_btb (
      .i_clk        (i_clk),
      .i_arst       (i_arst),
      .i_pc         (r_pc),
      .o_taken      (w_pred_taken),
      .o_target     (w_pred_target),
      .o_way        (w_pred_way),
      .i_upd        (i_btb_update),
      .i_upd_pc     (i_pc_exec),
      .i_upd_target (i_pc_target_exec),
      .i_upd_way    (i_btb_way_exec),
      .i_upd_taken  (i_branch_taken_exec)
   );
`else
   logic w_unused_upd;
   assign w_pred_taken  = 1'b0;
   assign w_pred_target = '0;
   assign w_pred_way    = '0;
   assign w_unused_upd  = ^{i_btb_update, i_pc_exec, i_pc_target_exec, i_btb_way_exec, i_branch_taken_exec};
`endif

   // Redirect wins over stall; a cache miss holds the PC like a stall does.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         r_pc <= RESET_PC;
      end else if (i_branch_mispred) begin
         r_pc <= i_pc_new;
      end else if (!i_stall_fetch && i_instr_valid) begin
         r_pc <= w_pred_taken ? w_pred_target : w_pc_plus4;
      end
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         r_instr       <= INSTR_WIDTH'(NOP_INSTR);
         r_fd_pc       <= '0;
         r_fd_pc_plus4 <= '0;
         r_fd_target   <= '0;
         r_fd_way      <= '0;
         r_fd_taken    <= 1'b0;
      end else if (i_flush_dec || (!i_stall_fetch && !i_instr_valid)) begin
         r_instr       <= INSTR_WIDTH'(NOP_INSTR);
         r_fd_pc       <= '0;
         r_fd_pc_plus4 <= '0;
         r_fd_target   <= '0;
         r_fd_way      <= '0;
         r_fd_taken    <= 1'b0;
      end else if (!i_stall_fetch) begin
         r_instr       <= i_instr;
         r_fd_pc       <= r_pc;
         r_fd_pc_plus4 <= w_pc_plus4;
         r_fd_target   <= w_pred_target;
         r_fd_way      <= w_pred_way;
         r_fd_taken    <= w_pred_taken;
      end
   end

   assign o_imem_addr         = r_pc;
   assign o_instruction       = r_instr;
   assign o_pc                = r_fd_pc;
   assign o_pc_plus4          = r_fd_pc_plus4;
   assign o_pc_target_pred    = r_fd_target;
   assign o_btb_way           = r_fd_way;
   assign o_branch_pred_taken = r_fd_taken;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; BTB expectations follow the BTB_EN build option.
module tb_fetch_stage;

`ifdef BTB_EN
   localparam bit BTB_ON = 1'b1;
`else
   localparam bit BTB_ON = 1'b0;
`endif

   localparam logic [63:0] B     = 64'h0000_0000_8000_0000;
   localparam logic [63:0] PMISS = 64'h0000_0000_A000_0024;

   logic        clk = 1'b0;
   logic        arst;
   logic [31:0] instr;
   logic        instr_valid, stall, flush, mispred;
   logic [63:0] pc_new;
   logic        btb_update;
   logic [63:0] pc_exec, pc_target_exec;
   logic [1:0]  btb_way_exec;
   logic        taken_exec;
   logic [63:0] imem_addr, o_pc, o_pc_plus4, o_target;
   logic [31:0] o_instr;
   logic [1:0]  o_way;
   logic        o_taken;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fetch_stage #(
      .ADDR_WIDTH  (64),
      .INSTR_WIDTH (32),
      .BTB_SETS    (16),
      .RESET_PC    (64'h0000_0000_8000_0000)
   ) dut (
      .i_clk               (clk),
      .i_arst              (arst),
      .i_instr             (instr),
      .i_instr_valid       (instr_valid),
      .i_stall_fetch       (stall),
      .i_flush_dec         (flush),
      .i_branch_mispred    (mispred),
      .i_pc_new            (pc_new),
      .i_btb_update        (btb_update),
      .i_pc_exec           (pc_exec),
      .i_pc_target_exec    (pc_target_exec),
      .i_btb_way_exec      (btb_way_exec),
      .i_branch_taken_exec (taken_exec),
      .o_imem_addr         (imem_addr),
      .o_instruction       (o_instr),
      .o_pc                (o_pc),
      .o_pc_plus4          (o_pc_plus4),
      .o_pc_target_pred    (o_target),
      .o_btb_way           (o_way),
      .o_branch_pred_taken (o_taken)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_upd(input logic en, input logic [63:0] pc, input logic [63:0] tgt,
                          input logic [1:0] way, input logic tk);
      btb_update     = en;
      pc_exec        = pc;
      pc_target_exec = tgt;
      btb_way_exec   = way;
      taken_exec     = tk;
   endtask

   task automatic redirect(input logic [63:0] a);
      mispred = 1'b1;
      pc_new  = a;
      tick();
      mispred = 1'b0;
   endtask

   initial begin
      logic [63:0] ak, tk;
      arst = 1'b1; instr = 32'h0010_0093; instr_valid = 1'b1; stall = 1'b0; flush = 1'b0;
      mispred = 1'b0; pc_new = '0;
      set_upd(1'b0, '0, '0, 2'd0, 1'b0);
      #2;
      chk("rst_pc", imem_addr, B);
      chk("rst_instr", {32'h0, o_instr}, 64'h13);
      chk("rst_fd_pc", o_pc, 64'h0);
      chk("rst_way_taken", {61'h0, o_way, o_taken}, 64'h0);
      #6 arst = 1'b0;

      tick();
      chk("seq_pc1", imem_addr, B + 64'h4);
      chk("seq_instr1", {32'h0, o_instr}, 64'h0010_0093);
      chk("seq_fdpc1", o_pc, B);
      tick();
      chk("seq_pc2", imem_addr, B + 64'h8);
      chk("seq_plus4_2", o_pc_plus4, B + 64'h8);

      // allocate taken entry for B+0x10 while fetching B+0x8
      set_upd(1'b1, B + 64'h10, B + 64'h100, 2'd0, 1'b1);
      tick();
      set_upd(1'b0, '0, '0, 2'd0, 1'b0);
      tick();
      chk("pc_at_10", imem_addr, B + 64'h10);
      tick();
      chk("hit_next_pc", imem_addr, BTB_ON ? B + 64'h100 : B + 64'h14);
      chk("hit_taken", {63'h0, o_taken}, {63'h0, BTB_ON});
      chk("hit_target", o_target, BTB_ON ? B + 64'h100 : 64'h0);
      chk("hit_way", {62'h0, o_way}, 64'h0);

      // same-cycle update/lookup: lookup sees WT before decrement
      redirect(B + 64'h10);
      chk("redir_pc", imem_addr, B + 64'h10);
      set_upd(1'b1, B + 64'h10, B + 64'h100, 2'd0, 1'b0);
      tick();
      chk("preupd_pc", imem_addr, BTB_ON ? B + 64'h100 : B + 64'h14);
      chk("preupd_taken", {63'h0, o_taken}, {63'h0, BTB_ON});
      tick();
      tick();
      set_upd(1'b0, '0, '0, 2'd0, 1'b0);
      redirect(B + 64'h10);
      tick();
      chk("snt_pc", imem_addr, B + 64'h14);
      chk("snt_taken", {63'h0, o_taken}, 64'h0);
      chk("snt_way", {62'h0, o_way}, 64'h0);

      set_upd(1'b1, B + 64'h10, B + 64'h100, 2'd0, 1'b1);
      for (int i = 0; i < 4; i++) tick();
      set_upd(1'b0, '0, '0, 2'd0, 1'b0);
      redirect(B + 64'h10);
      tick();
      chk("st_pc", imem_addr, BTB_ON ? B + 64'h100 : B + 64'h14);
      chk("st_taken", {63'h0, o_taken}, {63'h0, BTB_ON});

      // redirect with stall and flush
      stall = 1'b1; flush = 1'b1;
      redirect(B + 64'h200);
      chk("mp_stall_pc", imem_addr, B + 64'h200);
      chk("flush_instr", {32'h0, o_instr}, 64'h13);
      chk("flush_fdpc", o_pc, 64'h0);
      stall = 1'b0; flush = 1'b0; instr = 32'hDEAD_0001;
      tick();
      chk("cap_pc", imem_addr, B + 64'h204);
      chk("cap_instr", {32'h0, o_instr}, 64'hDEAD_0001);
      stall = 1'b1; instr = 32'h1234_5678;
      tick();
      chk("stall_pc", imem_addr, B + 64'h204);
      chk("stall_instr", {32'h0, o_instr}, 64'hDEAD_0001);
      chk("stall_fdpc", o_pc, B + 64'h200);
      stall = 1'b0;

      instr_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("miss_pc", imem_addr, B + 64'h204);
         chk("miss_bubble", {32'h0, o_instr}, 64'h13);
         chk("miss_fdpc", o_pc, 64'h0);
      end
      instr_valid = 1'b1; instr = 32'hCAFE_0013;
      tick();
      chk("resume_pc", imem_addr, B + 64'h208);
      chk("resume_instr", {32'h0, o_instr}, 64'hCAFE_0013);
      chk("resume_fdpc", o_pc, B + 64'h204);
      chk("resume_plus4", o_pc_plus4, B + 64'h208);

      // five allocations into set 9: round-robin 0,1,2,3,0
      for (int k = 0; k < 5; k++) begin
         ak = 64'h9000_0024 + 64'(k) * 64'h1000;
         tk = 64'h8000_0400 + 64'(k) * 64'h40;
         redirect(PMISS);
         set_upd(1'b1, ak, tk, 2'(k % 4), 1'b1);
         tick();
         set_upd(1'b0, '0, '0, 2'd0, 1'b0);
         chk("rr_way", {62'h0, o_way}, BTB_ON ? 64'(k % 4) : 64'h0);
         chk("rr_fdpc", o_pc, PMISS);
      end
      redirect(64'h9000_0024);
      tick();
      chk("evict_pc", imem_addr, 64'h9000_0028);
      chk("evict_taken", {63'h0, o_taken}, 64'h0);
      chk("evict_way", {62'h0, o_way}, BTB_ON ? 64'h1 : 64'h0);
      redirect(64'h9000_1024);
      tick();
      chk("keep1_pc", imem_addr, BTB_ON ? 64'h8000_0440 : 64'h9000_1028);
      chk("keep1_way", {62'h0, o_way}, BTB_ON ? 64'h1 : 64'h0);
      redirect(64'h9000_4024);
      tick();
      chk("new4_pc", imem_addr, BTB_ON ? 64'h8000_0500 : 64'h9000_4028);
      chk("new4_taken", {63'h0, o_taken}, {63'h0, BTB_ON});

      // PC+4 wraps at the top of the address space
      redirect(64'hFFFF_FFFF_FFFF_FFFC);
      tick();
      chk("wrap_pc", imem_addr, 64'h0);
      chk("wrap_plus4", o_pc_plus4, 64'h0);

      // asynchronous reset between edges
      #2 arst = 1'b1;
      #1;
      chk("arst_pc", imem_addr, B);
      chk("arst_instr", {32'h0, o_instr}, 64'h13);
      chk("arst_fdpc", o_pc, 64'h0);
      arst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
